// File: rtl/n_serial_out_pkg.sv
// Shared sizing and state encoding for the packed-vector to lane serializer.
// Lane geometry lives here only; the serializer keeps no local copies.
package n_serial_out_pkg;

   localparam int CELL_N = 4;
   localparam int D_LEN  = 32;
   localparam int DWIDTH = CELL_N * D_LEN;
   localparam int IDX_W  = (CELL_N > 1) ? $clog2(CELL_N) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_N - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

endpackage

// File: rtl/n_serial_out_if.sv
// Handshake bundle between the multiplier array, the serializer and the lane consumer.
// slave is the serializer side; master is whoever drives vectors in and accepts lanes out.
interface n_serial_out_if;
   import n_serial_out_pkg::*;

   logic              vin_valid;
   logic [DWIDTH-1:0] vin_data;
   logic              vin_ready;
   logic              sout_valid;
   logic              sout_ready;
   logic [D_LEN-1:0]  sout_data;
   logic [IDX_W-1:0]  sout_idx;
   logic              sout_last;

   modport slave (
      input  vin_valid,
      input  vin_data,
      output vin_ready,
      output sout_valid,
      input  sout_ready,
      output sout_data,
      output sout_idx,
      output sout_last
   );

   modport master (
      output vin_valid,
      output vin_data,
      input  vin_ready,
      input  sout_valid,
      output sout_ready,
      input  sout_data,
      input  sout_idx,
      input  sout_last
   );

endinterface

// File: rtl/n_serial_out.sv
// Serializes one packed product vector from the multiplier array into CELL_N lanes,
// lane 0 first, one lane per accepted output beat.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | holding register empty, waiting for a vector
//   ST_SEND | holding register loaded, presenting lane r_cnt downstream
module n_serial_out
   import n_serial_out_pkg::*;
(
   input  logic          mult_clk,
   input  logic          rst_n,
   n_serial_out_if.slave bus
);

   state_t            r_state;
   logic              r_valid;
   logic [IDX_W-1:0]  r_cnt;
   logic [DWIDTH-1:0] r_hold;

   logic              w_last_lane;
   logic              w_vin_ready;
   logic              w_in_xfer;
   logic              w_out_xfer;
   logic [D_LEN-1:0]  w_lane;

   assign w_last_lane = (r_cnt == LAST_IDX);
   assign w_out_xfer  = r_valid & bus.sout_ready;

   // Reload is only offered on the beat that drains the last lane, so a new vector
   // follows the old one with no bubble; vin_valid never feeds back into ready.
   assign w_vin_ready = rst_n &
                        ((r_state == ST_IDLE) |
                         ((r_state == ST_SEND) & w_last_lane & bus.sout_ready));
   assign w_in_xfer   = bus.vin_valid & w_vin_ready;

   assign w_lane      = r_hold[r_cnt*D_LEN +: D_LEN];

   always_ff @(posedge mult_clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
         r_cnt   <= '0;
         r_hold  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_in_xfer) begin
                  r_hold  <= bus.vin_data;
                  r_cnt   <= '0;
                  r_valid <= 1'b1;
                  r_state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (w_out_xfer) begin
                  if (!w_last_lane) begin
                     r_cnt <= r_cnt + 1'b1;
                  end else if (w_in_xfer) begin
                     r_hold <= bus.vin_data;
                     r_cnt  <= '0;
                  end else begin
                     r_hold  <= '0;
                     r_cnt   <= '0;
                     r_valid <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_hold  <= '0;
               r_cnt   <= '0;
               r_valid <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are forced to zero for as long as rst_n is low, not just after the edge.
   assign bus.vin_ready  = w_vin_ready;
   assign bus.sout_valid = rst_n & r_valid;
   assign bus.sout_data  = rst_n ? w_lane : '0;
   assign bus.sout_idx   = rst_n ? r_cnt : '0;
   assign bus.sout_last  = rst_n & r_valid & w_last_lane;

endmodule

// File: tb/tb_n_serial_out.sv
// Scoreboard bench for n_serial_out: accepted vectors are split into expected lanes,
// a monitor checks every presented lane and the handshake levels against that queue.
module tb_n_serial_out;
   import n_serial_out_pkg::*;

   typedef struct {
      logic [D_LEN-1:0] data;
      logic [IDX_W-1:0] idx;
      logic             last;
   } exp_lane_t;

   logic mult_clk = 1'b0;
   logic rst_n    = 1'b0;

   n_serial_out_if bus();

   n_serial_out dut (
      .mult_clk (mult_clk),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   always #5 mult_clk = ~mult_clk;

   exp_lane_t         exp_q[$];
   int                n_checks = 0;
   int                n_errors = 0;
   int                n_pops   = 0;
   int                n_acc    = 0;
   logic [DWIDTH-1:0] cur_vec;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [DWIDTH-1:0] rand_vec();
      logic [DWIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < CELL_N; i++) v[i*D_LEN +: D_LEN] = D_LEN'($urandom);
      return v;
   endfunction

   // Reference model: a vector becomes CELL_N lanes in ascending lane order.
   task automatic push_vec(input logic [DWIDTH-1:0] v);
      exp_lane_t e;
      for (int i = 0; i < CELL_N; i++) begin
         e.data = v[i*D_LEN +: D_LEN];
         e.idx  = IDX_W'(i);
         e.last = (i == CELL_N - 1);
         exp_q.push_back(e);
      end
   endtask

   // Inputs change on the falling edge; the push happens after the monitor has
   // sampled, so the monitor always sees the queue as of the previous rising edge.
   task automatic step(input logic vv, input logic sr);
      @(negedge mult_clk);
      bus.vin_valid  = vv;
      bus.sout_ready = sr;
      bus.vin_data   = cur_vec;
      #2;
      if (rst_n && vv && bus.vin_ready === 1'b1) begin
         push_vec(cur_vec);
         n_acc++;
         cur_vec = rand_vec();
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 64 && exp_q.size() > 0; k++) step(1'b0, 1'b1);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   always @(negedge mult_clk) begin : monitor
      exp_lane_t f;
      #1;
      if (!rst_n) begin
         chk("rst_sout_valid", 64'(bus.sout_valid), 64'd0);
         chk("rst_sout_data",  64'(bus.sout_data),  64'd0);
         chk("rst_sout_idx",   64'(bus.sout_idx),   64'd0);
         chk("rst_sout_last",  64'(bus.sout_last),  64'd0);
         chk("rst_vin_ready",  64'(bus.vin_ready),  64'd0);
         exp_q.delete();
      end else begin
         chk("sout_valid", 64'(bus.sout_valid), 64'(exp_q.size() > 0));
         chk("vin_ready",  64'(bus.vin_ready),
             64'((exp_q.size() == 0) || (exp_q.size() == 1 && bus.sout_ready === 1'b1)));
         if (exp_q.size() > 0) begin
            f = exp_q[0];
            chk("sout_data", 64'(bus.sout_data), 64'(f.data));
            chk("sout_idx",  64'(bus.sout_idx),  64'(f.idx));
            chk("sout_last", 64'(bus.sout_last), 64'(f.last));
            if (bus.sout_ready === 1'b1) begin
               void'(exp_q.pop_front());
               n_pops++;
            end
         end else begin
            chk("idle_sout_last", 64'(bus.sout_last), 64'd0);
         end
      end
   end

   initial begin
      int start;
      bus.vin_valid  = 1'b0;
      bus.sout_ready = 1'b0;
      bus.vin_data   = '0;
      cur_vec        = rand_vec();

      repeat (3) @(negedge mult_clk);
      rst_n = 1'b1;

      // Basic drain of a known float vector
      cur_vec = {32'h4040_0000, 32'h4000_0000, 32'hBF80_0000, 32'h3F80_0000};
      step(1'b1, 1'b1);
      drain();

      // Two vectors back to back: 8 lanes on 8 consecutive beats
      start = n_pops;
      repeat (9) step(1'b1, 1'b1);
      chk("b2b_lanes", 64'(n_pops - start), 64'd8);
      drain();

      // Backpressure held on lane 1 while a new vector is being offered
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      repeat (5) step(1'b1, 1'b0);
      drain();

      // Reset after lane 1, then a fresh vector must start at lane 0
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      @(negedge mult_clk);
      rst_n         = 1'b0;
      bus.vin_valid = 1'b0;
      @(negedge mult_clk);
      rst_n = 1'b1;
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      drain();

      // Idle gap with and without downstream ready
      repeat (3) step(1'b0, 1'b1);
      repeat (2) step(1'b0, 1'b0);

      // Random valid/ready over 1000 vectors
      start = n_acc;
      for (int c = 0; c < 60000 && (n_acc - start) < 1000; c++)
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      chk("rand_vectors", 64'(n_acc - start), 64'd1000);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/n_serial_out.md
N_SERIAL_OUT -- requirements
Module: n_serial_out

Interface
REQ-001 Macro CELL_N, default 4: number of float lanes per packed vector.
REQ-002 Macro D_LEN, default 32: width of one float lane in bits.
REQ-003 Macro DWIDTH, default CELL_N*D_LEN: width of the packed vector.
REQ-004 Macro IDX_W, default 2, equal to clog2(CELL_N) with a minimum of 1: lane index width.
REQ-005 mult_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 vin_valid  input  1  packed product vector present on vin_data.
REQ-008 vin_data  input  DWIDTH  packed vector; lane i occupies bits [i*D_LEN+D_LEN-1 : i*D_LEN].
REQ-009 vin_ready  output  1  block can accept a vector this cycle.
REQ-010 sout_valid  output  1  sout_data holds a valid lane.
REQ-011 sout_ready  input  1  downstream accepts the lane this cycle.
REQ-012 sout_data  output  D_LEN  current lane value.
REQ-013 sout_idx  output  IDX_W  lane number of sout_data.
REQ-014 sout_last  output  1  high when sout_idx equals CELL_N-1.

Function
REQ-015 Input transfer SHALL occur on a rising edge where vin_valid and vin_ready are both high; output transfer SHALL occur where sout_valid and sout_ready are both high.
REQ-016 On an input transfer, vin_data SHALL be captured into a DWIDTH holding register, and the lane counter SHALL be set to 0.
REQ-017 The block SHALL use a two-state FSM: IDLE, with holding register empty, and SEND, with holding register loaded.
REQ-018 In IDLE, vin_ready SHALL be 1 and sout_valid SHALL be 0; an input transfer SHALL move the FSM to SEND.
REQ-019 In SEND, sout_valid SHALL be 1, sout_data SHALL be the lane selected by the counter, and sout_idx SHALL equal the counter.
REQ-020 Lanes SHALL be emitted in ascending order, lane 0 first.
REQ-021 In SEND, an output transfer with counter < CELL_N-1 SHALL increment the counter; without a transfer, all outputs SHALL hold stable.
REQ-022 vin_ready SHALL be 1 in SEND only when sout_last, sout_valid and sout_ready are all high; it SHALL be 0 in SEND otherwise.
REQ-023 An output transfer of the last lane together with an input transfer SHALL load the new vector, reset the counter to 0, and stay in SEND with no bubble cycle.
REQ-024 An output transfer of the last lane without an input transfer SHALL return the FSM to IDLE.
REQ-025 Latency from an input transfer to the first sout_valid SHALL be 1 cycle.
REQ-026 Sustained throughput SHALL be one lane per cycle, i.e. one vector per CELL_N cycles, when sout_ready is held at 1.
REQ-027 Lane data SHALL pass through bit-exact; the block SHALL perform no float interpretation.
REQ-028 vin_ready SHALL depend combinationally only on state, counter and sout_ready, never on vin_valid.
REQ-029 sout_valid SHALL NOT depend on sout_ready.

Reset
REQ-030 When rst_n is 0 at a clock edge, the block SHALL set the FSM to IDLE and the counter to 0, and SHALL clear the holding register.
REQ-031 While in reset, outputs SHALL be: sout_valid=0, sout_data=0, sout_idx=0, sout_last=0, vin_ready=0.
REQ-032 A reset asserted while a vector is being emitted SHALL discard the remaining lanes; no partial lane SHALL be emitted after rst_n returns to 1.
REQ-033 After rst_n returns to 1, vin_ready SHALL be 1 from the first following edge.

Structure
REQ-034 CELL_N, D_LEN, DWIDTH and IDX_W SHALL reside in the shared extern.v include; the block SHALL define no local copies.
REQ-035 The block SHALL be a single module with no sub-module; lane selection SHALL be an indexed part-select of the holding register.
REQ-036 The block SHALL be placed directly downstream of the multiplier array, consuming its packed product vector.

Verification
REQ-037 Basic drain (CELL_N=4, D_LEN=32): load vin_data={32'h4040_0000, 32'h4000_0000, 32'hBF80_0000, 32'h3F80_0000} with sout_ready=1 -> output 3F800000, BF800000, 40000000, 40400000 with idx 0..3 on 4 consecutive cycles, sout_last only on idx 3.
REQ-038 Back-to-back: two vectors offered continuously with sout_ready=1 -> 8 consecutive valid lanes with no gap; vin_ready pulses high on the idx 3 cycle only.
REQ-039 Backpressure: sout_ready=0 for 5 cycles during idx 1 -> sout_data and sout_idx stay stable, no lane is lost or duplicated, and vin_ready stays 0.
REQ-040 Reset mid-vector: assert rst_n=0 after idx 1 is emitted -> next cycle sout_valid=0; after release, a new vector starts at idx 0 with the new data.
REQ-041 Idle gap: vin_valid=0 after the last lane -> FSM returns to IDLE, sout_valid=0, vin_ready=1.
REQ-042 Random: random vin_valid/sout_ready over 1000 vectors -> scoreboard matches all lanes in order; vin_ready and sout_valid are never X.
